// File: rtl/cmp_result_monitor.sv
// Debounces the one-hot A>B / A=B / A<B comparator result stream into a stable relation
// state, with registered crossing events, a saturating crossing counter and a one-hot error flag.
module cmp_result_monitor #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             ans2,
    input  logic             ans1,
    input  logic             ans0,
    input  logic             clr_cnt,
    output logic [1:0]       state_o,
    output logic             evt_rise,
    output logic             evt_fall,
    output logic [CNT_W-1:0] cross_cnt,
    output logic             err_onehot
);

    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] ST_UNKNOWN = 2'b00;
    localparam logic [1:0] ST_BELOW   = 2'b01;
    localparam logic [1:0] ST_EQUAL   = 2'b10;
    localparam logic [1:0] ST_ABOVE   = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       last_cand_q, last_cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             evt_rise_q, evt_rise_d;
    logic             evt_fall_q, evt_fall_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       cand;
    logic             legal;
    logic             qualify;

    // Candidates share the state encoding so a qualified candidate is the new state directly.
    always_comb begin
        cand  = ST_UNKNOWN;
        legal = 1'b0;
        case ({ans2, ans1, ans0})
            3'b100: begin cand = ST_ABOVE; legal = 1'b1; end
            3'b010: begin cand = ST_EQUAL; legal = 1'b1; end
            3'b001: begin cand = ST_BELOW; legal = 1'b1; end
            default: begin cand = ST_UNKNOWN; legal = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNKNOWN;
            last_cand_q <= ST_UNKNOWN;
            run_q       <= '0;
            evt_rise_q  <= 1'b0;
            evt_fall_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_cand_q <= last_cand_d;
            run_q       <= run_d;
            evt_rise_q  <= evt_rise_d;
            evt_fall_q  <= evt_fall_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_cand_d = last_cand_q;
        run_d       = run_q;
        qualify     = 1'b0;
        if (in_valid) begin
            if (!legal) begin
                run_d = '0;
            end else begin
                if (cand == last_cand_q && run_q != '0) begin
                    run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
                end else begin
                    run_d = RUN_W'(1);
                end
                last_cand_d = cand;
                if (run_d == RUN_MAX && cand != state_q) begin
                    qualify = 1'b1;
                    state_d = cand;
                end
            end
        end
    end

    // Only entries into ABOVE or BELOW from a known state count as crossings.
    always_comb begin
        err_d      = in_valid && !legal;
        evt_rise_d = qualify && cand == ST_ABOVE &&
                     (state_q == ST_BELOW || state_q == ST_EQUAL);
        evt_fall_d = qualify && cand == ST_BELOW &&
                     (state_q == ST_EQUAL || state_q == ST_ABOVE);
        if (clr_cnt) begin
            cnt_d = '0;
        end else if ((evt_rise_d || evt_fall_d) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign state_o    = state_q;
    assign evt_rise   = evt_rise_q;
    assign evt_fall   = evt_fall_q;
    assign cross_cnt  = cnt_q;
    assign err_onehot = err_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Scoreboard bench for cmp_result_monitor: directed scenarios then randomized traffic,
// checked against a sliding-window reference model of the debounce rules.
module tb_cmp_result_monitor;

    localparam int D  = 3;
    localparam int CW = 2;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          ans2 = 1'b0, ans1 = 1'b0, ans0 = 1'b0;
    logic          clr_cnt = 1'b0;
    logic [1:0]    state_o;
    logic          evt_rise, evt_fall, err_onehot;
    logic [CW-1:0] cross_cnt;

    cmp_result_monitor #(.DEBOUNCE(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ans2(ans2), .ans1(ans1), .ans0(ans0), .clr_cnt(clr_cnt),
        .state_o(state_o), .evt_rise(evt_rise), .evt_fall(evt_fall),
        .cross_cnt(cross_cnt), .err_onehot(err_onehot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int rise;
        int fall;
        int cnt;
        int err;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    // Reference model: relation 0 unknown, 1 below, 2 equal, 3 above.
    int   m_state = 0;
    int   m_cnt   = 0;
    int   win[$];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] expv, int c);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, c, got, expv);
    endfunction

    task automatic step(input bit r, input bit v, input logic [2:0] a, input bit c);
        exp_t e;
        int   cand;
        bit   ok;
        @(negedge clk);
        rst = r; in_valid = v; {ans2, ans1, ans0} = a; clr_cnt = c;
        cyc++;
        e.rise = 0; e.fall = 0; e.err = 0; e.cyc = cyc;
        if (r) begin
            m_state = 0; m_cnt = 0; win.delete();
        end else begin
            if (v) begin
                if ($countones(a) == 1) begin
                    cand = (a == 3'b100) ? 3 : (a == 3'b010) ? 2 : 1;
                    win.push_back(cand);
                    if (win.size() > 16) void'(win.pop_front());
                    ok = (win.size() >= D);
                    for (int k = 0; k < D && ok; k++)
                        if (win[win.size() - 1 - k] != cand) ok = 0;
                    if (ok && cand != m_state) begin
                        if (cand == 3 && (m_state == 1 || m_state == 2)) e.rise = 1;
                        if (cand == 1 && (m_state == 2 || m_state == 3)) e.fall = 1;
                        m_state = cand;
                    end
                end else begin
                    e.err = 1;
                    win.delete();
                end
            end
            if (c) m_cnt = 0;
            else if (e.rise || e.fall) m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
        end
        e.st = m_state; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic sv(input logic [2:0] a);
        step(0, 1, a, 0);
    endtask

    task automatic idle();
        step(0, 0, 3'b000, 0);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents a registered output word.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state_o",    state_o,    e.st,   e.cyc);
            chk("evt_rise",   evt_rise,   e.rise, e.cyc);
            chk("evt_fall",   evt_fall,   e.fall, e.cyc);
            chk("cross_cnt",  cross_cnt,  e.cnt,  e.cyc);
            chk("err_onehot", err_onehot, e.err,  e.cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        logic [2:0] cur;
        logic [2:0] ill;
        logic [2:0] legal_pat [3];
        logic [2:0] illegal_pat [5];
        legal_pat   = '{3'b100, 3'b010, 3'b001};
        illegal_pat = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        // 1: reset, then three BELOW samples qualify without an event
        step(1, 0, 3'b000, 0);
        step(1, 0, 3'b000, 0);
        sync();
        chk("t1_reset_state", state_o, 0, cyc);
        chk("t1_reset_cnt", cross_cnt, 0, cyc);
        sv(3'b001); sv(3'b001);
        sync();
        chk("t1_two_samples", state_o, 0, cyc);
        sv(3'b001);
        sync();
        chk("t1_state_below", state_o, 1, cyc);
        chk("t1_no_rise", evt_rise, 0, cyc);
        chk("t1_cnt", cross_cnt, 0, cyc);

        // 2: an EQUAL sample breaks the ABOVE run
        sv(3'b100); sv(3'b100); sv(3'b010); sv(3'b100); sv(3'b100);
        sync();
        chk("t2_hold_below", state_o, 1, cyc);
        sv(3'b100);
        sync();
        chk("t2_state_above", state_o, 3, cyc);
        chk("t2_rise", evt_rise, 1, cyc);
        chk("t2_cnt", cross_cnt, 1, cyc);
        idle();
        sync();
        chk("t2_rise_pulse_end", evt_rise, 0, cyc);

        // 3: gaps do not break a run
        sv(3'b001); idle(); idle(); idle(); idle(); sv(3'b001);
        sync();
        chk("t3_hold_above", state_o, 3, cyc);
        sv(3'b001);
        sync();
        chk("t3_state_below", state_o, 1, cyc);
        chk("t3_fall", evt_fall, 1, cyc);
        chk("t3_cnt", cross_cnt, 2, cyc);

        // 4: illegal sample restarts the run
        sv(3'b100); sv(3'b100); sv(3'b011);
        sync();
        chk("t4_err", err_onehot, 1, cyc);
        sv(3'b100);
        sync();
        chk("t4_err_pulse_end", err_onehot, 0, cyc);
        chk("t4_hold_below", state_o, 1, cyc);
        sv(3'b100); sv(3'b100);
        sync();
        chk("t4_state_above", state_o, 3, cyc);

        // 5: counter saturation and clear priority
        step(0, 0, 3'b000, 1);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < D; j++) sv((i % 2 == 0) ? 3'b001 : 3'b100);
        sync();
        chk("t5_saturated", cross_cnt, CNT_SAT, cyc);
        sv(3'b100); sv(3'b100); step(0, 1, 3'b100, 1);
        sync();
        chk("t5_clr_rise", evt_rise, 1, cyc);
        chk("t5_clr_wins", cross_cnt, 0, cyc);

        // 6: reset discards a partial run
        sv(3'b001); sv(3'b001);
        step(1, 0, 3'b000, 0);
        sync();
        chk("t6_reset_state", state_o, 0, cyc);
        sv(3'b001);
        sync();
        chk("t6_no_qualify", state_o, 0, cyc);

        // Randomized traffic
        cur = 3'b100;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) cur = legal_pat[$urandom_range(2)];
            ill = illegal_pat[$urandom_range(4)];
            step($urandom_range(199) == 0, $urandom_range(7) != 0,
                 ($urandom_range(9) == 0) ? ill : cur, $urandom_range(39) == 0);
        end
        idle();
        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0, cyc);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
